key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, stable-sample count needed to accept a level change (20 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25000000, held time before the first auto-repeat pulse (used only with KEY_AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_CYCLES, default 10000000, interval between auto-repeat pulses (used only with KEY_AUTOREPEAT_EN).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 key_raw  input  3  raw push buttons, active-low (0 = pressed), asynchronous to clk; bit 0 interface, bit 1 start_or_stop, bit 2 choose_mode.
REQ-007 key_level  output  3  debounced level, active-low, glitch-free; drives the menu/mode/start switch stage directly.
REQ-008 key_press  output  3  one-cycle pulse per accepted press (and per auto-repeat).
REQ-009 key_release  output  3  one-cycle pulse per accepted release.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each key SHALL own a counter whose width is ceil(log2(DEB_CYCLES+1)) bits; while synced != key_level it increments; while equal it clears to 0.
REQ-012 When the counter reaches DEB_CYCLES-1 with synced still != key_level, key_level SHALL take synced on the next edge and the counter SHALL clear.
REQ-013 Latency raw edge -> key_level change SHALL be exactly 2 + DEB_CYCLES cycles for a clean edge.
REQ-014 Any excursion lasting fewer than DEB_CYCLES synchronized cycles SHALL leave key_level unchanged and produce no pulse.
REQ-015 key_press SHALL be high for exactly the cycle in which key_level goes 1->0; key_release for the cycle in which it goes 0->1.
REQ-016 Keys SHALL be fully independent; simultaneous acceptances SHALL yield simultaneous pulses on each bit.
REQ-017 Counters SHALL never wrap; no state beyond DEB_CYCLES-1 is reachable.

Reset
REQ-018 While clrn=0: synchronizer flops = 1, key_level = 3'b111, key_press = key_release = 0, all counters = 0.
REQ-019 Reset asserted mid-count SHALL discard the partial count; a key held through reset release SHALL be accepted as a press DEB_CYCLES+2 cycles later.
REQ-020 No pulse SHALL be emitted on the cycle reset deasserts.

Configuration
REQ-021 Macro KEY_AUTOREPEAT_EN defined: per-key hold counter runs while key_level=0; first extra key_press pulse at HOLD_CYCLES after the accepted press, then one every REPEAT_CYCLES; hold counter clears on release or reset; key_level is unaffected.
REQ-022 Macro undefined: hold counters and related logic are absent; exactly one key_press per accepted press.

Structure
REQ-023 Shared package key_pkg SHALL hold NUM_KEYS=3, key index constants KEY_INTERFACE=0, KEY_START=1, KEY_MODE=2, and default cycle constants.
REQ-024 One sub-module key_debounce_1ch (synchronizer, debounce counter, pulse generation, optional repeat) SHALL be instantiated NUM_KEYS times; the top only wires buses.

Verification (bench uses DEB_CYCLES=8, HOLD_CYCLES=40, REPEAT_CYCLES=16)
REQ-025 Reset, keys idle -> key_level=111, no pulses for 100 cycles.
REQ-026 key_raw[2] low and held -> key_level[2]=0 and a single key_press[2] pulse exactly 10 cycles after the raw edge.
REQ-027 key_raw[0] low for 5 cycles then high (bounce) -> no change, no pulse; low for 8+ cycles -> accepted.
REQ-028 Keys 0 and 1 pressed on the same cycle -> key_press[0] and key_press[1] pulse on the same cycle; release of key 1 -> key_release[1] only.
REQ-029 clrn pulsed low while counter = 5 -> counter cleared; held key accepted 10 cycles after clrn returns high.
REQ-030 KEY_AUTOREPEAT_EN, key 2 held 100 cycles after acceptance -> pulses at +0, +40, +56, +72, +88; none without the macro.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// key_pkg: key count, key indices and default timing for the key conditioner.
// Build option: define KEY_AUTOREPEAT_EN to add held-key auto-repeat.
package key_pkg;

    localparam int NUM_KEYS      = 3;
    localparam int KEY_INTERFACE = 0;
    localparam int KEY_START     = 1;
    localparam int KEY_MODE      = 2;

    localparam int unsigned DEB_CYCLES_DEF    = 1000000;
    localparam int unsigned HOLD_CYCLES_DEF   = 25000000;
    localparam int unsigned REPEAT_CYCLES_DEF = 10000000;

    function automatic int cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// key_if: raw active-low buttons in, debounced level and pulses out.
// master drives the raw keys; slave is the conditioner.
interface key_if;
    import key_pkg::*;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release
    );

endinterface

// File: rtl/key_conditioner_debounce.sv
// key_debounce_1ch: synchronizer, debounce counter and press/release pulses.
// Define KEY_AUTOREPEAT_EN to emit repeated presses while a key is held.
module key_debounce_1ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic clrn,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("key_debounce_1ch: cycle parameters must be at least 1");
    end

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          diff;
    logic          accept;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = cnt_width(HMAX);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
`endif

    always_comb begin
        sync_d  = {sync_q[0], raw};
        diff    = sync_q[1] ^ level_q;
        accept  = diff && (cnt_q == DEB_MAX);
        cnt_d   = (diff && !accept) ? cnt_q + 1'b1 : '0;
        level_d = accept ? sync_q[1] : level_q;
        press_d = accept && !sync_q[1];
        rel_d   = accept && sync_q[1];
`ifdef KEY_AUTOREPEAT_EN
        // Hold timer runs only while the accepted level is pressed.
        hold_d = '0;
        rep_d  = 1'b0;
        if (!level_q && !accept) begin
            if (hold_q == (rep_q ? REP_MAX : HOLD_MAX)) begin
                press_d = 1'b1;
                rep_d   = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
                rep_d  = rep_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= '0;
            rep_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= hold_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: one debounce channel per push button.
// Define KEY_AUTOREPEAT_EN to enable held-key auto-repeat in every channel.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  clrn,
    key_if.slave  kif
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_1ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_deb (
            .clk   (clk),
            .clrn  (clrn),
            .raw   (kif.key_raw[i]),
            .level (kif.key_level[i]),
            .press (kif.key_press[i]),
            .rel   (kif.key_release[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: pulses are matched against a cycle-stamped queue.
// Expectations follow KEY_AUTOREPEAT_EN when it is defined.
module tb_key_conditioner;
    import key_pkg::*;

    localparam int D = 8;
    localparam int H = 40;
    localparam int R = 16;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
    } ev_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    ev_t  sb[$];
    ev_t  mev;

    key_if kif();

    key_conditioner #(
        .DEB_CYCLES    (D),
        .HOLD_CYCLES   (H),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .kif  (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, logic [2:0] p, logic [2:0] r);
        ev_t e;
        e.cyc = c;
        e.press = p;
        e.rel = r;
        sb.push_back(e);
    endfunction

    // Every pulse must be the next queued event at its stamped cycle.
    always @(negedge clk) begin
        if (mon_en && (kif.key_press !== 3'b000 || kif.key_release !== 3'b000)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b want none",
                         cyc, kif.key_press, kif.key_release);
            end else begin
                mev = sb.pop_front();
                if (mev.cyc !== cyc || mev.press !== kif.key_press || mev.rel !== kif.key_release) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d press=%b rel=%b want cyc=%0d press=%b rel=%b",
                             cyc, kif.key_press, kif.key_release, mev.cyc, mev.press, mev.rel);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_pulse pending=%0d next_cyc=%0d want 0 pending",
                     sb.size(), sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        kif.key_raw = 3'b111;
        repeat (3) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111 || kif.key_press !== 3'b000 || kif.key_release !== 3'b000) begin
            bad++;
            $display("FAIL reset_state level=%b press=%b rel=%b want 111/000/000",
                     kif.key_level, kif.key_press, kif.key_release);
        end
        clrn = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if (kif.key_level !== 3'b111) begin
                bad++;
                $display("FAIL idle_level cyc=%0d level=%b want 111", cyc, kif.key_level);
            end
        end
    endtask

    task automatic test_press_hold();
        int t;
        @(negedge clk);
        kif.key_raw[KEY_MODE] = 1'b0;
        t = cyc;
        push(t + D + 2, 3'b100, 3'b000);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 4; k++)
            push(t + D + 2 + H + k * R, 3'b100, 3'b000);
`endif
        push(t + D + 2 + 100, 3'b000, 3'b100);
        repeat (D + 1) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL pre_accept level=%b want 111", kif.key_level);
        end
        @(negedge clk);
        total++;
        if (kif.key_level !== 3'b011) begin
            bad++;
            $display("FAIL accept_level level=%b want 011", kif.key_level);
        end
        repeat (90) @(negedge clk);
        kif.key_raw[KEY_MODE] = 1'b1;
        drain();
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL hold_release_level level=%b want 111", kif.key_level);
        end
    endtask

    task automatic test_bounce();
        int t;
        @(negedge clk);
        kif.key_raw[KEY_INTERFACE] = 1'b0;
        repeat (5) @(negedge clk);
        kif.key_raw[KEY_INTERFACE] = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL bounce5_level level=%b want 111", kif.key_level);
        end
        kif.key_raw[KEY_INTERFACE] = 1'b0;
        repeat (D - 1) @(negedge clk);
        kif.key_raw[KEY_INTERFACE] = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL bounce7_level level=%b want 111", kif.key_level);
        end
        kif.key_raw[KEY_INTERFACE] = 1'b0;
        t = cyc;
        push(t + D + 2, 3'b001, 3'b000);
        push(t + D + D + 2, 3'b000, 3'b001);
        repeat (D) @(negedge clk);
        kif.key_raw[KEY_INTERFACE] = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b110) begin
            bad++;
            $display("FAIL min_press_level level=%b want 110", kif.key_level);
        end
        drain();
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL min_release_level level=%b want 111", kif.key_level);
        end
    endtask

    task automatic test_simultaneous();
        int t;
        @(negedge clk);
        kif.key_raw[1:0] = 2'b00;
        t = cyc;
        push(t + 10, 3'b011, 3'b000);
        push(t + 40, 3'b000, 3'b010);
        push(t + 45, 3'b000, 3'b001);
        repeat (10) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b100) begin
            bad++;
            $display("FAIL simul_level level=%b want 100", kif.key_level);
        end
        repeat (20) @(negedge clk);
        kif.key_raw[KEY_START] = 1'b1;
        repeat (5) @(negedge clk);
        kif.key_raw[KEY_INTERFACE] = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b110) begin
            bad++;
            $display("FAIL single_release_level level=%b want 110", kif.key_level);
        end
        drain();
    endtask

    task automatic test_reset_mid_count();
        int r;
        @(negedge clk);
        kif.key_raw[KEY_START] = 1'b0;
        repeat (7) @(negedge clk);
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111 || kif.key_press !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_state level=%b press=%b want 111/000",
                     kif.key_level, kif.key_press);
        end
        clrn = 1'b1;
        r = cyc;
        push(r + D + 2, 3'b010, 3'b000);
        repeat (D + 1) @(negedge clk);
        total++;
        if (kif.key_level !== 3'b111) begin
            bad++;
            $display("FAIL post_reset_partial level=%b want 111", kif.key_level);
        end
        @(negedge clk);
        total++;
        if (kif.key_level !== 3'b101) begin
            bad++;
            $display("FAIL post_reset_accept level=%b want 101", kif.key_level);
        end
        kif.key_raw[KEY_START] = 1'b1;
        push(cyc + D + 2, 3'b000, 3'b010);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d want bench end", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_press_hold();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
